write_stream: RTL

- Write-side counterpart of the READ block.
- Accepts a data stream over the valid/avail handshake, buffers it in a small FIFO, and issues sequential writes into a MEM instance.
- Address sequence: base_address, incrementing over num_iters x num_writes_per_iter items.
- Sits between a producer (e.g. a distribute/collect output lane) and the MEM write port (data_write/addr_write/write).

---
 rtl/write_stream.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/write_stream.sv
// write_stream: takes a stream over a valid/avail handshake, buffers it in a
// small FIFO and writes it to sequential MEM addresses starting at base_address.
// Optional build macro WRITE_OVERFLOW_CHECK_EN adds a sticky `error` output.
// It flags items that had to be dropped: FIFO full, not running, or surplus items.
module write_stream #(
   parameter int DATA_WIDTH              = 16,
   parameter int LOG_MAX_ITERS           = 4,
   parameter int LOG_MAX_WRITES_PER_ITER = 8,
   parameter int LOG_MAX_ADDRESS         = 12,
   parameter int FIFO_DEPTH              = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               configure,
   input  logic [LOG_MAX_ITERS-1:0]           num_iters,
   input  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter,
   input  logic [LOG_MAX_ADDRESS-1:0]         base_address,
   input  logic                               valid_in,
   input  logic [DATA_WIDTH-1:0]              data_in,
   output logic                               avail_out,
   input  logic                               mem_ready,
   output logic                               write,
   output logic [LOG_MAX_ADDRESS-1:0]         addr_write,
   output logic [DATA_WIDTH-1:0]              data_write,
   output logic                               done
`ifdef WRITE_OVERFLOW_CHECK_EN
   ,
   output logic                               error
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TOT_W = LOG_MAX_ITERS + LOG_MAX_WRITES_PER_ITER;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_reg, state_next;

   // latched configuration
   logic [LOG_MAX_ITERS-1:0]           iters_reg;
   logic [LOG_MAX_WRITES_PER_ITER-1:0] wpi_reg;
   logic [TOT_W-1:0]                   total_reg, total_next;

   // progress counters
   logic [TOT_W-1:0]                   accepted_reg, accepted_next;
   logic [LOG_MAX_ITERS-1:0]           iter_reg;
   logic [LOG_MAX_WRITES_PER_ITER-1:0] idx_reg;
   logic [LOG_MAX_ADDRESS-1:0]         addr_reg;
   logic                               last_pend_reg;

   // input buffer
   logic [DATA_WIDTH-1:0]              fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]                   wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]                   count_reg, count_next;

   logic             in_run, push, pop, last_pop, fifo_full, fifo_empty, avail_next;
   logic [TOT_W-1:0] total_cfg;

   assign total_cfg  = TOT_W'(num_iters) * TOT_W'(num_writes_per_iter);
   assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_reg == '0);

   // A configure pulse in RUN wins over any push/pop in the same cycle
   assign in_run   = (state_reg == RUN) && !configure;
   assign push     = in_run && valid_in && !fifo_full && (accepted_reg != total_reg);
   assign pop      = in_run && !fifo_empty && mem_ready;
   assign last_pop = pop && (iter_reg == iters_reg - 1'b1) && (idx_reg == wpi_reg - 1'b1);

   assign count_next    = configure ? '0 : count_reg + CNT_W'(push) - CNT_W'(pop);
   assign accepted_next = configure ? '0 : accepted_reg + TOT_W'(push);
   assign total_next    = configure ? total_cfg : total_reg;

   // Producer sees avail one cycle late, so keep two free slots of slack
   assign avail_next = (state_next == RUN) &&
                       ((CNT_W'(FIFO_DEPTH) - count_next) >= CNT_W'(2)) &&
                       (accepted_next != total_next);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   // Next-state logic; a zero-length job or the strobe of the last write ends RUN
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (configure) state_next = RUN;
         RUN: begin
            if (configure)                              state_next = RUN;
            else if (total_reg == '0 || last_pend_reg) state_next = DONE;
         end
         DONE: if (configure) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // FIFO storage, no reset needed: occupancy alone says what is valid
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= data_in;
   end

   // Datapath: configuration, counters, FIFO pointers and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iters_reg     <= '0;
         wpi_reg       <= '0;
         total_reg     <= '0;
         accepted_reg  <= '0;
         iter_reg      <= '0;
         idx_reg       <= '0;
         addr_reg      <= '0;
         last_pend_reg <= 1'b0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         avail_out     <= 1'b0;
         write         <= 1'b0;
         addr_write    <= '0;
         data_write    <= '0;
         done          <= 1'b0;
      end else begin
         total_reg    <= total_next;
         accepted_reg <= accepted_next;
         count_reg    <= count_next;
         avail_out    <= avail_next;
         write        <= pop;
         done         <= (state_next == DONE);
         if (configure) begin
            iters_reg     <= num_iters;
            wpi_reg       <= num_writes_per_iter;
            addr_reg      <= base_address;
            iter_reg      <= '0;
            idx_reg       <= '0;
            last_pend_reg <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
         end else begin
            last_pend_reg <= last_pop;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
               addr_write <= addr_reg;
               data_write <= fifo_mem[rd_ptr_reg];
               addr_reg   <= addr_reg + 1'b1;
               if (idx_reg == wpi_reg - 1'b1) begin
                  idx_reg  <= '0;
                  iter_reg <= iter_reg + 1'b1;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
         end
      end
   end

`ifdef WRITE_OVERFLOW_CHECK_EN
   // Sticky flag for any offered item that could not be accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   error <= 1'b0;
      else if (configure)         error <= 1'b0;
      else if (valid_in && !push) error <= 1'b1;
   end
`endif

endmodule
